ps2_scan_rx: RTL and testbench

PS2_SCAN_RX -- requirements
Module: ps2_scan_rx

---
 rtl/ps2_scan_rx_pkg.sv | 19 +
 rtl/ps2_line_filter.sv | 42 ++++
 rtl/ps2_scan_rx.sv | 139 +++++++++++++
 tb/tb_ps2_scan_rx.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_scan_rx_pkg.sv
// Shared constants for the PS/2 scan-code receiver: prefix bytes and frame FSM encoding.
package ps2_scan_rx_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rxState_t;

  // Odd parity: the eight data bits plus the parity bit must hold an odd number of ones.
  function automatic logic oddParityOk(input logic [7:0] dataByte, input logic parBit);
    return ^{dataByte, parBit};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser and glitch filter for one raw PS/2 line; idles high.
module ps2_line_filter #(
  parameter int FILTER = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic filt
);

  localparam int CNT_W = (FILTER < 2) ? 1 : $clog2(FILTER + 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] holdCnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Filtered level flips only once the synchronised level has disagreed for FILTER cycles in a row.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      filt    <= 1'b1;
      holdCnt <= '0;
    end else if (sync_p1 == filt) begin
      holdCnt <= '0;
    end else if (holdCnt == CNT_W'(FILTER - 1)) begin
      filt    <= sync_p1;
      holdCnt <= '0;
    end else begin
      holdCnt <= holdCnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: frames 11-bit words, strips F0/E0 prefixes and reports make/break codes.
module ps2_scan_rx
  import ps2_scan_rx_pkg::*;
#(
  parameter int FREQ_KHZ   = 48000,
  parameter int FILTER     = 16,
  parameter int TIMEOUT_US = 2000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2Ck,
  input  logic       ps2D,
  output logic       strb,
  output logic       make,
  output logic       ext,
  output logic [7:0] code,
  output logic       err
);

  localparam int TO_CYCLES = FREQ_KHZ * TIMEOUT_US / 1000;
  localparam int TO_W      = $clog2(TO_CYCLES + 1);

  logic            ckFilt;
  logic            dFilt;
  logic            ckPrev;
  logic            ckFall;
  rxState_t        state;
  rxState_t        nextState;
  logic [7:0]      shiftReg;
  logic [2:0]      bitCnt;
  logic            parBit;
  logic [TO_W-1:0] toCnt;
  logic            toExpire;
  logic            brkFlag;
  logic            extFlag;

  ps2_line_filter #(.FILTER(FILTER)) ckFilter (
    .clock (clock),
    .reset (reset),
    .raw   (ps2Ck),
    .filt  (ckFilt)
  );

  ps2_line_filter #(.FILTER(FILTER)) dFilter (
    .clock (clock),
    .reset (reset),
    .raw   (ps2D),
    .filt  (dFilt)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ckPrev <= 1'b1;
    else        ckPrev <= ckFilt;
  end

  assign ckFall   = ckPrev & ~ckFilt;
  assign toExpire = (state != IDLE) && !ckFall && (toCnt == TO_W'(TO_CYCLES - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    if (toExpire) begin
      nextState = IDLE;
    end else if (ckFall) begin
      case (state)
        IDLE:    if (!dFilt) nextState = DATA;
        DATA:    if (bitCnt == 3'd7) nextState = PARITY;
        PARITY:  nextState = STOP;
        STOP:    nextState = IDLE;
        default: nextState = IDLE;
      endcase
    end
  end

  // Frame datapath, prefix flags and registered result/err pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shiftReg <= '0;
      bitCnt   <= '0;
      parBit   <= 1'b0;
      toCnt    <= '0;
      brkFlag  <= 1'b0;
      extFlag  <= 1'b0;
      strb     <= 1'b0;
      err      <= 1'b0;
      make     <= 1'b0;
      ext      <= 1'b0;
      code     <= '0;
    end else begin
      strb <= 1'b0;
      err  <= 1'b0;

      if (state == IDLE || ckFall) toCnt <= '0;
      else                         toCnt <= toCnt + TO_W'(1);

      if (toExpire) begin
        err     <= 1'b1;
        brkFlag <= 1'b0;
        extFlag <= 1'b0;
        bitCnt  <= '0;
      end else if (ckFall) begin
        case (state)
          IDLE: bitCnt <= '0;
          DATA: begin
            shiftReg <= {dFilt, shiftReg[7:1]};
            bitCnt   <= bitCnt + 3'd1;
          end
          PARITY: parBit <= dFilt;
          STOP: begin
            if (oddParityOk(shiftReg, parBit) && dFilt) begin
              if (shiftReg == PS2_BREAK) begin
                brkFlag <= 1'b1;
              end else if (shiftReg == PS2_EXT) begin
                extFlag <= 1'b1;
              end else begin
                strb    <= 1'b1;
                code    <= shiftReg;
                make    <= ~brkFlag;
                ext     <= extFlag;
                brkFlag <= 1'b0;
                extFlag <= 1'b0;
              end
            end else begin
              err     <= 1'b1;
              brkFlag <= 1'b0;
              extFlag <= 1'b0;
            end
          end
          default: bitCnt <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Bench for ps2_scan_rx: vector table, hand-written corner cases and random frames vs a byte-level model.
module tb_ps2_scan_rx;

  localparam int FREQ_KHZ   = 1000;
  localparam int FILTER     = 4;
  localparam int TIMEOUT_US = 200;
  localparam int HALF       = 12;
  localparam int SETTLE     = 8;
  localparam int NTBL       = 16;
  localparam int NRAND      = 40;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ps2Ck = 1'b1;
  logic       ps2D  = 1'b1;
  logic       strb;
  logic       make;
  logic       ext;
  logic [7:0] code;
  logic       err;

  ps2_scan_rx #(
    .FREQ_KHZ   (FREQ_KHZ),
    .FILTER     (FILTER),
    .TIMEOUT_US (TIMEOUT_US)
  ) dut (
    .clock (clock),
    .reset (reset),
    .ps2Ck (ps2Ck),
    .ps2D  (ps2D),
    .strb  (strb),
    .make  (make),
    .ext   (ext),
    .code  (code),
    .err   (err)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         kind;   // 0 none, 1 strb, 2 err
    logic [7:0] code;
    logic       make;
    logic       ext;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    bit         flipPar;
    bit         badStop;
    int         expKind;
    logic [7:0] expCode;
    logic       expMake;
    logic       expExt;
  } vec_t;

  ev_t  evQ[$];
  vec_t tbl[NTBL];
  int   passCnt  = 0;
  int   totalCnt = 0;
  bit   bothHigh = 1'b0;
  bit   holdViol = 1'b0;
  logic [7:0] prevCode = 8'h00;
  logic       prevMake = 1'b0;
  logic       prevExt  = 1'b0;
  logic       prevRst  = 1'b0;
  bit   mBrk = 1'b0;
  bit   mExt = 1'b0;

  // Event monitor sampled on the inactive edge.
  always @(negedge clock) begin
    ev_t e;
    if (strb && err) bothHigh = 1'b1;
    if (reset && prevRst && !strb &&
        (code !== prevCode || make !== prevMake || ext !== prevExt)) holdViol = 1'b1;
    if (strb) begin
      e.kind = 1; e.code = code; e.make = make; e.ext = ext;
      evQ.push_back(e);
    end else if (err) begin
      e.kind = 2; e.code = 8'h00; e.make = 1'b0; e.ext = 1'b0;
      evQ.push_back(e);
    end
    prevCode = code; prevMake = make; prevExt = ext; prevRst = reset;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic sendFrame(input logic [7:0] b, input bit flipPar, input bit badStop, input int nBits);
    logic [10:0] bits;
    bits = {~badStop, (~^b) ^ flipPar, b, 1'b0};
    for (int i = 0; i < nBits; i++) begin
      ps2D = bits[i];
      repeat (HALF) @(posedge clock);
      ps2Ck = 1'b0;
      repeat (HALF) @(posedge clock);
      ps2Ck = 1'b1;
    end
    ps2D = 1'b1;
    repeat (HALF + SETTLE) @(posedge clock);
  endtask

  task automatic expectEvent(input string name, input int kind, input logic [7:0] c,
                             input logic m, input logic x);
    check({name, "_count"}, evQ.size(), (kind == 0) ? 0 : 1);
    if (kind != 0 && evQ.size() > 0) begin
      check({name, "_kind"}, evQ[0].kind, kind);
      if (kind == 1) begin
        check({name, "_code"}, evQ[0].code, c);
        check({name, "_make"}, evQ[0].make, m);
        check({name, "_ext"},  evQ[0].ext,  x);
      end
    end
    evQ.delete();
  endtask

  // Byte-level reference: odd parity and stop bit decide validity, prefixes only update flags.
  task automatic modelFrame(input logic [7:0] b, input bit flipPar, output int kind,
                            output logic [7:0] c, output logic m, output logic x);
    int ones;
    ones = $countones(b) + ((~^b) ^ flipPar);
    kind = 0; c = 8'h00; m = 1'b0; x = 1'b0;
    if (ones % 2 == 1) begin
      if (b == 8'hF0) mBrk = 1'b1;
      else if (b == 8'hE0) mExt = 1'b1;
      else begin
        kind = 1; c = b; m = ~mBrk; x = mExt;
        mBrk = 1'b0; mExt = 1'b0;
      end
    end else begin
      kind = 2; mBrk = 1'b0; mExt = 1'b0;
    end
  endtask

  initial begin
    tbl[0]  = '{8'h1C, 0, 0, 1, 8'h1C, 1, 0};
    tbl[1]  = '{8'hE0, 0, 0, 0, 8'h00, 0, 0};
    tbl[2]  = '{8'hF0, 0, 0, 0, 8'h00, 0, 0};
    tbl[3]  = '{8'h75, 0, 0, 1, 8'h75, 0, 1};
    tbl[4]  = '{8'h1C, 1, 0, 2, 8'h00, 0, 0};
    tbl[5]  = '{8'h32, 0, 0, 1, 8'h32, 1, 0};
    tbl[6]  = '{8'hF0, 0, 0, 0, 8'h00, 0, 0};
    tbl[7]  = '{8'h1C, 1, 0, 2, 8'h00, 0, 0};
    tbl[8]  = '{8'h29, 0, 0, 1, 8'h29, 1, 0};
    tbl[9]  = '{8'hE1, 0, 0, 1, 8'hE1, 1, 0};
    tbl[10] = '{8'hAA, 0, 0, 1, 8'hAA, 1, 0};
    tbl[11] = '{8'hFA, 0, 0, 1, 8'hFA, 1, 0};
    tbl[12] = '{8'hFE, 0, 0, 1, 8'hFE, 1, 0};
    tbl[13] = '{8'h00, 0, 0, 1, 8'h00, 1, 0};
    tbl[14] = '{8'hE0, 0, 1, 2, 8'h00, 0, 0};
    tbl[15] = '{8'h5A, 0, 0, 1, 8'h5A, 1, 0};

    repeat (4) @(posedge clock);
    #1;
    check("rst_strb", strb, 0);
    check("rst_err",  err,  0);
    check("rst_make", make, 0);
    check("rst_ext",  ext,  0);
    check("rst_code", code, 8'h00);
    reset = 1'b1;
    repeat (30) @(posedge clock);
    check("rst_release_quiet", evQ.size(), 0);
    evQ.delete();

    for (int i = 0; i < NTBL; i++) begin
      sendFrame(tbl[i].data, tbl[i].flipPar, tbl[i].badStop, 11);
      expectEvent($sformatf("vec%0d", i), tbl[i].expKind, tbl[i].expCode,
                  tbl[i].expMake, tbl[i].expExt);
    end

    // Truncated frame then a long idle: timeout error, then clean decode.
    sendFrame(8'h29, 0, 0, 5);
    repeat (400) @(posedge clock);
    expectEvent("timeout", 2, 8'h00, 0, 0);
    sendFrame(8'h29, 0, 0, 11);
    expectEvent("after_timeout", 1, 8'h29, 1, 0);

    // Short clock glitches with data low must not start a frame.
    ps2D = 1'b0;
    repeat (20) @(posedge clock);
    for (int g = 0; g < 5; g++) begin
      ps2Ck = 1'b0;
      repeat (FILTER - 2) @(posedge clock);
      ps2Ck = 1'b1;
      repeat (10) @(posedge clock);
    end
    ps2D = 1'b1;
    repeat (20) @(posedge clock);
    expectEvent("glitch_quiet", 0, 8'h00, 0, 0);
    sendFrame(8'h3B, 0, 0, 11);
    expectEvent("after_glitch", 1, 8'h3B, 1, 0);

    // Reset in the middle of a frame, with an ext prefix pending.
    sendFrame(8'hE0, 0, 0, 11);
    sendFrame(8'h16, 0, 0, 6);
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("midrst_strb", strb, 0);
    check("midrst_err",  err,  0);
    check("midrst_make", make, 0);
    check("midrst_ext",  ext,  0);
    check("midrst_code", code, 8'h00);
    reset = 1'b1;
    repeat (20) @(posedge clock);
    evQ.delete();
    sendFrame(8'h16, 0, 0, 11);
    expectEvent("after_midrst", 1, 8'h16, 1, 0);

    mBrk = 1'b0;
    mExt = 1'b0;
    for (int r = 0; r < NRAND; r++) begin
      logic [7:0] b;
      bit         fp;
      int         k;
      logic [7:0] c;
      logic       m;
      logic       x;
      case ($urandom_range(0, 9))
        0:       b = 8'hF0;
        1:       b = 8'hE0;
        default: b = 8'($urandom_range(0, 255));
      endcase
      fp = ($urandom_range(0, 7) == 0);
      sendFrame(b, fp, 0, 11);
      modelFrame(b, fp, k, c, m, x);
      expectEvent($sformatf("rand%0d_%02h", r, b), k, c, m, x);
    end

    check("strb_err_exclusive", bothHigh, 0);
    check("outputs_hold", holdViol, 0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
